// File: rtl/axi4_wr_resp_merge_pkg.sv
// Shared types and helpers for the write-response merger: AXI response encoding,
// FSM state encoding and the response-class accumulation rules.
package axi4_wr_resp_merge_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExOkay = 2'd1,
    RespSlvErr = 2'd2,
    RespDecErr = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StResp    = 2'd2
  } state_e;

  // Sub-burst count reaches 2**lsize when every beat is its own sub-burst.
  function automatic int unsigned nsub_width(int unsigned lsize);
    return lsize + 1;
  endfunction

  // Only error classes escalate the accumulator; the worst error seen wins.
  function automatic axi_resp_t err_merge(axi_resp_t err, axi_resp_t bresp);
    if ((bresp >= RespSlvErr) && (bresp > err)) begin
      return bresp;
    end
    return err;
  endfunction

  // Final merged class once bresp is folded into the running err/exok state.
  function automatic axi_resp_t resp_merge(axi_resp_t err, logic exok, axi_resp_t bresp);
    axi_resp_t err_n;
    logic      exok_n;
    err_n  = err_merge(err, bresp);
    exok_n = exok & (bresp == RespExOkay);
    if (err_n >= RespSlvErr) begin
      return err_n;
    end
    return exok_n ? RespExOkay : RespOkay;
  endfunction

endpackage

// File: rtl/axi4_wr_resp_merge_fifo.sv
// Show-ahead synchronous FIFO tracking outstanding long writes.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module axi4_wr_resp_merge_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             one_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      level;

  assign level   = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign one_o   = (level == (AW+1)'(1));
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) begin
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/axi4_wr_resp_merge.sv
// Merges the short B responses of a partitioned long write back into one B carrying
// the original AWID, with the worst error (or all-EXOKAY) response class.
module axi4_wr_resp_merge
  import axi4_wr_resp_merge_pkg::*;
#(
  parameter int unsigned PSIZE  = 128,
  parameter int unsigned IDSIZE = 4,
  parameter int unsigned LSIZE  = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              up_awvalid,
  output logic              up_awready,
  input  logic [IDSIZE-1:0] up_awid,
  input  logic [LSIZE-1:0]  up_awlen,
  output logic              dn_awvalid,
  input  logic              dn_awready,
  input  logic              short_bvalid,
  output logic              short_bready,
  input  logic [1:0]        short_bresp,
  output logic              long_bvalid,
  input  logic              long_bready,
  output logic [IDSIZE-1:0] long_bid,
  output logic [1:0]        long_bresp
);

  localparam int unsigned NW = nsub_width(LSIZE);
  localparam int unsigned EW = IDSIZE + NW;

  logic              trk_full, trk_empty, trk_one;
  logic              push, pop;
  logic [NW-1:0]     aw_nsub;
  logic [EW-1:0]     head;
  logic [IDSIZE-1:0] hd_id;
  logic [NW-1:0]     hd_nsub;
  logic              short_hs, long_hs;
  axi_resp_t         bresp_in;

  state_e            state_q, state_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  axi_resp_t         err_q, err_d;
  logic              exok_q, exok_d;
  logic              short_bready_q, short_bready_d;
  logic              long_bvalid_q, long_bvalid_d;
  logic [IDSIZE-1:0] long_bid_q, long_bid_d;
  axi_resp_t         long_bresp_q, long_bresp_d;

  // AW passes straight through; only the tracker-full condition gates it.
  assign up_awready = dn_awready & ~trk_full;
  assign dn_awvalid = up_awvalid & ~trk_full;
  assign push       = up_awvalid & dn_awready & ~trk_full;

  assign aw_nsub = NW'(32'(up_awlen) / PSIZE) + NW'(1);

  axi4_wr_resp_merge_fifo #(
    .Width (EW),
    .Depth (DEPTH)
  ) u_trk (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .push_i  (push),
    .wdata_i ({up_awid, aw_nsub}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .one_o   (trk_one)
  );

  assign hd_id    = head[EW-1:NW];
  assign hd_nsub  = head[NW-1:0];
  assign bresp_in = axi_resp_t'(short_bresp);
  assign short_hs = short_bvalid & short_bready_q;
  assign long_hs  = long_bvalid_q & long_bready;
  assign pop      = (state_q == StResp) & long_hs;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    exok_d         = exok_q;
    short_bready_d = short_bready_q;
    long_bvalid_d  = long_bvalid_q;
    long_bid_d     = long_bid_q;
    long_bresp_d   = long_bresp_q;
    unique case (state_q)
      StIdle: begin
        if (!trk_empty) begin
          state_d        = StCollect;
          cnt_d          = '0;
          err_d          = RespOkay;
          exok_d         = 1'b1;
          short_bready_d = 1'b1;
        end
      end
      StCollect: begin
        if (short_hs) begin
          cnt_d  = cnt_q + NW'(1);
          err_d  = err_merge(err_q, bresp_in);
          exok_d = exok_q & (bresp_in == RespExOkay);
          if (cnt_q == hd_nsub - NW'(1)) begin
            state_d        = StResp;
            short_bready_d = 1'b0;
            long_bvalid_d  = 1'b1;
            long_bid_d     = hd_id;
            long_bresp_d   = resp_merge(err_q, exok_q, bresp_in);
          end
        end
      end
      StResp: begin
        if (long_hs) begin
          long_bvalid_d = 1'b0;
          // A same-cycle push lands in the slot the head will point at next cycle.
          if (!trk_one || push) begin
            state_d        = StCollect;
            cnt_d          = '0;
            err_d          = RespOkay;
            exok_d         = 1'b1;
            short_bready_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d        = StIdle;
        short_bready_d = 1'b0;
        long_bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      err_q          <= RespOkay;
      exok_q         <= 1'b1;
      short_bready_q <= 1'b0;
      long_bvalid_q  <= 1'b0;
      long_bid_q     <= '0;
      long_bresp_q   <= RespOkay;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      exok_q         <= exok_d;
      short_bready_q <= short_bready_d;
      long_bvalid_q  <= long_bvalid_d;
      long_bid_q     <= long_bid_d;
      long_bresp_q   <= long_bresp_d;
    end
  end

  assign short_bready = short_bready_q;
  assign long_bvalid  = long_bvalid_q;
  assign long_bid     = long_bid_q;
  assign long_bresp   = long_bresp_q;

endmodule

// File: tb/tb_axi4_wr_resp_merge.sv
// Directed bench for axi4_wr_resp_merge: vector table of long writes with their short
// B sequences and expected merged responses, plus full, stall, stray-B and reset sequences.
module tb_axi4_wr_resp_merge;

  localparam int unsigned IDW = 4;
  localparam int unsigned LW  = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           up_awvalid, up_awready;
  logic [IDW-1:0] up_awid;
  logic [LW-1:0]  up_awlen;
  logic           dn_awvalid, dn_awready;
  logic           short_bvalid, short_bready;
  logic [1:0]     short_bresp;
  logic           long_bvalid, long_bready;
  logic [IDW-1:0] long_bid;
  logic [1:0]     long_bresp;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi4_wr_resp_merge #(
    .PSIZE  (128),
    .IDSIZE (IDW),
    .LSIZE  (LW),
    .DEPTH  (8)
  ) dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .up_awvalid   (up_awvalid),
    .up_awready   (up_awready),
    .up_awid      (up_awid),
    .up_awlen     (up_awlen),
    .dn_awvalid   (dn_awvalid),
    .dn_awready   (dn_awready),
    .short_bvalid (short_bvalid),
    .short_bready (short_bready),
    .short_bresp  (short_bresp),
    .long_bvalid  (long_bvalid),
    .long_bready  (long_bready),
    .long_bid     (long_bid),
    .long_bresp   (long_bresp)
  );

  typedef struct packed {
    logic [3:0]      id;
    logic [8:0]      len;
    logic [2:0]      nsub;
    logic [3:0][1:0] br;
    logic [1:0]      resp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_aw(input logic [IDW-1:0] id, input logic [LW-1:0] len);
    logic hs;
    hs = 1'b0;
    up_awvalid = 1'b1;
    up_awid    = id;
    up_awlen   = len;
    dn_awready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      hs = up_awready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    up_awvalid = 1'b0;
    chk("aw_accept", 32'(hs), 32'd1);
  endtask

  task automatic send_b(input logic [1:0] resp);
    logic hs;
    hs = 1'b0;
    short_bvalid = 1'b1;
    short_bresp  = resp;
    for (int k = 0; k < 50; k++) begin
      hs = short_bready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    short_bvalid = 1'b0;
    chk("short_b_accept", 32'(hs), 32'd1);
  endtask

  task automatic pop_long();
    chk("pop_long_bvalid", 32'(long_bvalid), 32'd1);
    long_bready = 1'b1;
    @(posedge clk);
    #1;
    long_bready = 1'b0;
  endtask

  task automatic check_long(input string name, input logic [IDW-1:0] id, input logic [1:0] resp);
    chk({name, "_bvalid"}, 32'(long_bvalid), 32'd1);
    chk({name, "_bid"}, 32'(long_bid), 32'(id));
    chk({name, "_bresp"}, 32'(long_bresp), 32'(resp));
    chk({name, "_short_bready"}, 32'(short_bready), 32'd0);
  endtask

  initial begin
    vecs[0] = '{id: 4'd3,  len: 9'd255, nsub: 3'd2, br: {2'd0, 2'd0, 2'd0, 2'd0}, resp: 2'd0};
    vecs[1] = '{id: 4'd5,  len: 9'd0,   nsub: 3'd1, br: {2'd0, 2'd0, 2'd0, 2'd2}, resp: 2'd2};
    vecs[2] = '{id: 4'd7,  len: 9'd383, nsub: 3'd3, br: {2'd0, 2'd2, 2'd3, 2'd0}, resp: 2'd3};
    vecs[3] = '{id: 4'd1,  len: 9'd255, nsub: 3'd2, br: {2'd0, 2'd0, 2'd1, 2'd1}, resp: 2'd1};
    vecs[4] = '{id: 4'd2,  len: 9'd255, nsub: 3'd2, br: {2'd0, 2'd0, 2'd0, 2'd1}, resp: 2'd0};
    vecs[5] = '{id: 4'd9,  len: 9'd127, nsub: 3'd1, br: {2'd0, 2'd0, 2'd0, 2'd1}, resp: 2'd1};
    vecs[6] = '{id: 4'd15, len: 9'd128, nsub: 3'd2, br: {2'd0, 2'd0, 2'd1, 2'd2}, resp: 2'd2};
    vecs[7] = '{id: 4'd6,  len: 9'd511, nsub: 3'd4, br: {2'd0, 2'd1, 2'd2, 2'd3}, resp: 2'd3};

    rst_n        = 1'b0;
    up_awvalid   = 1'b1;
    up_awid      = '0;
    up_awlen     = '0;
    dn_awready   = 1'b1;
    short_bvalid = 1'b0;
    short_bresp  = 2'd0;
    long_bready  = 1'b0;
    #2;
    chk("rst_up_awready", 32'(up_awready), 32'd1);
    chk("rst_dn_awvalid", 32'(dn_awvalid), 32'd1);
    chk("rst_short_bready", 32'(short_bready), 32'd0);
    chk("rst_long_bvalid", 32'(long_bvalid), 32'd0);
    chk("rst_long_bid", 32'(long_bid), 32'd0);
    chk("rst_long_bresp", 32'(long_bresp), 32'd0);
    dn_awready = 1'b0;
    #1;
    chk("rst_up_awready_gated", 32'(up_awready), 32'd0);
    up_awvalid = 1'b0;
    dn_awready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one long write, its short Bs in order, one merged B.
    for (int v = 0; v < 8; v++) begin
      send_aw(vecs[v].id, vecs[v].len);
      for (int k = 0; k < int'(vecs[v].nsub); k++) begin
        send_b(vecs[v].br[k]);
        if (k < int'(vecs[v].nsub) - 1) begin
          chk("early_long_bvalid", 32'(long_bvalid), 32'd0);
          chk("mid_short_bready", 32'(short_bready), 32'd1);
        end
      end
      check_long($sformatf("vec%0d", v), vecs[v].id, vecs[v].resp);
      pop_long();
      chk("after_pop_bvalid", 32'(long_bvalid), 32'd0);
    end

    // Stray short B with empty tracker is held off, then consumed by the next write.
    short_bvalid = 1'b1;
    short_bresp  = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("stray_short_bready", 32'(short_bready), 32'd0);
    end
    send_aw(4'd8, 9'd0);
    send_b(2'd1);
    check_long("stray", 4'd8, 2'd1);
    pop_long();

    // Back-pressure on the merged B.
    send_aw(4'd10, 9'd0);
    send_b(2'd2);
    short_bvalid = 1'b1;
    short_bresp  = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_long("stall", 4'd10, 2'd2);
    end
    short_bvalid = 1'b0;
    pop_long();
    chk("stall_after_pop_bvalid", 32'(long_bvalid), 32'd0);

    // Fill the tracker, then free one slot with a pop.
    for (int i = 0; i < 8; i++) begin
      send_aw(IDW'(i), 9'd0);
    end
    up_awvalid = 1'b1;
    up_awid    = 4'd8;
    up_awlen   = 9'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("full_up_awready", 32'(up_awready), 32'd0);
      chk("full_dn_awvalid", 32'(dn_awvalid), 32'd0);
    end
    send_b(2'd0);
    check_long("full_id0", 4'd0, 2'd0);
    chk("full_still_blocked", 32'(up_awready), 32'd0);
    pop_long();
    chk("freed_up_awready", 32'(up_awready), 32'd1);
    chk("freed_dn_awvalid", 32'(dn_awvalid), 32'd1);
    @(posedge clk);
    #1;
    up_awvalid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_b(2'd0);
      check_long($sformatf("drain%0d", i), IDW'(i), 2'd0);
      pop_long();
    end
    chk("drained_bvalid", 32'(long_bvalid), 32'd0);

    // Reset in the middle of collecting a two-sub-burst write.
    send_aw(4'd3, 9'd255);
    send_b(2'd0);
    chk("pre_rst_short_bready", 32'(short_bready), 32'd1);
    chk("pre_rst_long_bid", 32'(long_bid), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_short_bready", 32'(short_bready), 32'd0);
    chk("mid_rst_long_bvalid", 32'(long_bvalid), 32'd0);
    chk("mid_rst_long_bid", 32'(long_bid), 32'd0);
    chk("mid_rst_long_bresp", 32'(long_bresp), 32'd0);
    chk("mid_rst_up_awready", 32'(up_awready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    short_bvalid = 1'b1;
    short_bresp  = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_short_bready", 32'(short_bready), 32'd0);
      chk("post_rst_long_bvalid", 32'(long_bvalid), 32'd0);
    end
    short_bvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
